timer_sched: RTL and testbench

//  Round-robin scheduler that shares one 4-bit delay timer (1101 start pattern + 4 delay bits MSB-first,

---
 rtl/timer_sched.sv | 132 +++++++++++++
 tb/tb_timer_sched.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/timer_sched.sv
// Round-robin scheduler that shares one serial-programmed delay timer among N_REQ clients.
// It sends the 1101 + delay pattern, waits for counting/done, acks the timer and pulses done to the winner.
module timer_sched #(
    parameter int N_REQ    = 4,
    parameter int DLY_W    = 4,
    parameter int CNT_TMO  = 4,
    parameter int DONE_TMO = 816
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*DLY_W-1:0] delay,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic                   err,
    output logic                   tmr_data,
    output logic                   tmr_ack,
    input  logic                   tmr_counting,
    input  logic                   tmr_done,
    output logic [2:0]             dbg_state
);
    localparam int IDX_W   = $clog2(N_REQ);
    localparam int SER_LEN = 4 + DLY_W;
    localparam int BIT_W   = $clog2(SER_LEN + 1);
    localparam int TMO_W   = $clog2(DONE_TMO + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_SEND, S_WAIT_CNT, S_WAIT_DONE, S_ACK, S_GAP, S_ERR
    } state_t;

    state_t             r_state, w_nxt;
    logic [IDX_W-1:0]   r_rr, r_idx, w_win, w_cand;
    logic [DLY_W-1:0]   r_dly;
    logic [BIT_W-1:0]   r_bit;
    logic [TMO_W-1:0]   r_tmo;
    logic [N_REQ-1:0]   r_gnt, r_done;
    logic               r_tmr_data, r_tmr_ack;
    logic               w_found, w_data_nxt;
    logic [SER_LEN-1:0] w_pat;

    assign w_pat = {4'b1101, r_dly};

    // First requesting client at or after the round-robin pointer.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_rr;
        w_cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_cand = IDX_W'((int'(r_rr) + i) % N_REQ);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    // Valid/ready: none; tmr_data/tmr_ack are registered so the timer sees a full clean bit per cycle.
    always_comb begin
        w_nxt      = r_state;
        w_data_nxt = 1'b0;
        case (r_state)
            S_IDLE: if (|req) w_nxt = S_ARB;
            S_ARB: begin
                if (w_found) begin
                    w_nxt      = S_SEND;
                    w_data_nxt = 1'b1;
                end else begin
                    w_nxt = S_IDLE;
                end
            end
            S_SEND: begin
                if (r_bit == BIT_W'(SER_LEN - 1)) w_nxt = S_WAIT_CNT;
                else w_data_nxt = w_pat[BIT_W'(SER_LEN - 2) - r_bit];
            end
            S_WAIT_CNT: begin
                if (tmr_counting) w_nxt = S_WAIT_DONE;
                else if (r_tmo == TMO_W'(CNT_TMO - 1)) w_nxt = S_ERR;
            end
            S_WAIT_DONE: begin
                if (tmr_done) w_nxt = S_ACK;
                else if (r_tmo == TMO_W'(DONE_TMO - 1)) w_nxt = S_ERR;
            end
            S_ACK:   w_nxt = S_GAP;
            S_GAP:   w_nxt = S_IDLE;
            S_ERR:   w_nxt = S_ERR;
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_rr       <= '0;
            r_idx      <= '0;
            r_dly      <= '0;
            r_bit      <= '0;
            r_tmo      <= '0;
            r_gnt      <= '0;
            r_done     <= '0;
            r_tmr_data <= 1'b0;
            r_tmr_ack  <= 1'b0;
        end else begin
            r_state    <= w_nxt;
            r_tmr_data <= w_data_nxt;
            r_tmr_ack  <= (w_nxt == S_ACK);
            r_done     <= (w_nxt == S_ACK) ? (N_REQ'(1) << r_idx) : '0;
            r_bit      <= (r_state == S_SEND) ? r_bit + 1'b1 : '0;
            // Timeout counter only runs while waiting on the timer, restarting on every state change.
            if (w_nxt != r_state) r_tmo <= '0;
            else if (r_state == S_WAIT_CNT || r_state == S_WAIT_DONE) r_tmo <= r_tmo + 1'b1;
            if (r_state == S_ARB && w_found) begin
                r_idx <= w_win;
                r_dly <= delay[int'(w_win)*DLY_W +: DLY_W];
                r_gnt <= N_REQ'(1) << w_win;
            end
            if (r_state == S_ACK) begin
                r_gnt <= '0;
                r_rr  <= (r_idx == IDX_W'(N_REQ - 1)) ? '0 : r_idx + 1'b1;
            end
            if (w_nxt == S_ERR) r_gnt <= '0;
        end
    end

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign busy      = (r_state != S_IDLE);
    assign err       = (r_state == S_ERR);
    assign tmr_data  = r_tmr_data;
    assign tmr_ack   = r_tmr_ack;
    assign dbg_state = r_state;
endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched with a behavioural model of the shared serial delay timer.
module tb_timer_sched;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] delay;
    logic [3:0]  gnt, done;
    logic        busy, err, tmr_data, tmr_ack, tmr_counting, tmr_done;
    logic [2:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    timer_sched dut (
        .clk(clk), .reset(reset), .req(req), .delay(delay), .gnt(gnt), .done(done),
        .busy(busy), .err(err), .tmr_data(tmr_data), .tmr_ack(tmr_ack),
        .tmr_counting(tmr_counting), .tmr_done(tmr_done), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Timer model: detect 1101 + 4 delay bits, count (d+1)*50 cycles, raise done until acked.
    logic [7:0] m_sr;
    logic [3:0] m_last_dly;
    logic [1:0] m_phase;
    int         m_cnt;
    logic       never_count = 1'b0;
    wire  [7:0] m_w = {m_sr[6:0], tmr_data};

    assign tmr_counting = (m_phase == 2'd1);
    assign tmr_done     = (m_phase == 2'd2);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_sr       <= '0;
            m_last_dly <= '0;
            m_phase    <= 2'd0;
            m_cnt      <= 0;
        end else begin
            case (m_phase)
                2'd0: begin
                    if (m_w[7:4] == 4'b1101) begin
                        m_sr       <= '0;
                        m_last_dly <= m_w[3:0];
                        if (!never_count) begin
                            m_phase <= 2'd1;
                            m_cnt   <= (int'(m_w[3:0]) + 1) * 50;
                        end
                    end else begin
                        m_sr <= m_w;
                    end
                end
                2'd1: begin
                    m_cnt <= m_cnt - 1;
                    if (m_cnt == 1) m_phase <= 2'd2;
                end
                default: if (tmr_ack) m_phase <= 2'd0;
            endcase
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One whole job: grant, serial pattern, done pulse timing and one-cycle ack.
    task automatic run_job(input int idx, input logic [3:0] d);
        int n;
        logic [7:0] pat;
        pat = {4'b1101, d};
        n = 0;
        while (gnt == 4'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("gnt", 32'(gnt), 32'(4'b1 << idx));
        check_eq("busy", 32'(busy), 32'd1);
        n = 0;
        for (int k = 0; k < 8; k++) begin
            check_eq($sformatf("ser_bit%0d", k), 32'(tmr_data), 32'(pat[7-k]));
            @(negedge clk);
            n++;
        end
        check_eq("ser_idle", 32'(tmr_data), 32'd0);
        while (done == 4'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq("done", 32'(done), 32'(4'b1 << idx));
        check_eq("job_len", 32'(n), 32'((int'(d) + 1) * 50 + 9));
        check_eq("dly_rx", 32'(m_last_dly), 32'(d));
        check_eq("ack_hi", 32'(tmr_ack), 32'd1);
        check_eq("gnt_in_ack", 32'(gnt), 32'(4'b1 << idx));
        @(negedge clk);
        check_eq("done_pulse", 32'(done), 32'd0);
        check_eq("ack_pulse", 32'(tmr_ack), 32'd0);
        check_eq("gnt_clr", 32'(gnt), 32'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        req   = '0;
        delay = '0;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_outs", 32'({gnt, done, busy, err, tmr_data, tmr_ack}), 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'd0);
        reset = 1'b1;

        // T1: single client, delay 5
        delay = 16'h0005;
        req   = 4'b0001;
        run_job(0, 4'h5);
        req = 4'b0000;
        repeat (3) @(negedge clk);
        check_eq("idle_busy", 32'(busy), 32'd0);

        // T3: shortest and longest delays (pointer now at 1)
        delay = 16'hF000;
        req   = 4'b0100;
        run_job(2, 4'h0);
        req = 4'b1000;
        run_job(3, 4'hF);
        req = 4'b0000;
        check_eq("no_err_long", 32'(err), 32'd0);

        // T2: fairness with all clients requesting (pointer wrapped to 0)
        delay = 16'h0000;
        req   = 4'b1111;
        run_job(0, 4'h0);
        run_job(1, 4'h0);
        run_job(2, 4'h0);
        run_job(3, 4'h0);
        run_job(0, 4'h0);
        req = 4'b0000;

        // T5: client 1 drops its request during SEND; pointer then skips it
        delay = 16'h0021;
        req   = 4'b0011;
        fork
            begin
                repeat (4) @(negedge clk);
                req[1] = 1'b0;
            end
        join_none
        run_job(1, 4'h2);
        run_job(0, 4'h1);
        req = 4'b0000;

        // T6: asynchronous reset while waiting for the timer
        delay = 16'h0063;
        req   = 4'b0001;
        n = 0;
        while (!tmr_counting && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        check_eq("pre_rst_state", 32'(dbg_state), 32'd4);
        #2 reset = 1'b0;
        #1;
        check_eq("async_rst_outs", 32'({gnt, done, busy, err, tmr_data, tmr_ack}), 32'd0);
        check_eq("async_rst_state", 32'(dbg_state), 32'd0);
        req = 4'b0010;
        @(negedge clk);
        reset = 1'b1;
        run_job(1, 4'h6);
        req = 4'b0000;

        // T4: timer never starts counting -> sticky error
        never_count = 1'b1;
        req = 4'b0001;
        n = 0;
        while (gnt == 4'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("t4_gnt", 32'(gnt), 32'd1);
        n = 0;
        while (!err && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("t4_err_lat", 32'(n), 32'd12);
        check_eq("t4_err", 32'(err), 32'd1);
        check_eq("t4_gnt_clr", 32'(gnt), 32'd0);
        check_eq("t4_lines", 32'({tmr_data, tmr_ack}), 32'd0);
        req = 4'b1111;
        n = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (gnt != 4'b0 || done != 4'b0) n++;
        end
        check_eq("t4_no_grant", 32'(n), 32'd0);
        check_eq("t4_err_sticky", 32'(err), 32'd1);
        check_eq("t4_busy", 32'(busy), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
